z3_slave_ctrl: RTL

Z3_SLAVE_CTRL -- requirements
Module: z3_slave_ctrl

---
 rtl/z3_slave_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/z3_slave_ctrl.sv
// z3_slave_ctrl: Zorro III slave-cycle decoder; terminates on a target dtack or a
// saturating WAIT timeout, and rearms only after seeing the strobe released in IDLE.
module z3_slave_ctrl #(
    parameter int TIMEOUT_CYCLES = 63,
    parameter int CNT_W = 8
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       FCS_n,
    input  logic [7:0] ADDR_HI,
    input  logic       READ_pin,
    input  logic       configured,
    input  logic [7:0] base_addr,
    input  logic       sid_dtack,
    input  logic       scsi_dtack,
    output logic       slave_cycle,
    output logic       READ,
    output logic       dtack,
    output logic       timeout
);
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_TERM, S_IGNORE} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    state_t           state_q;
    logic [1:0]       fcs_sync_q, rd_sync_q, vld_q;
    logic [7:0]       addr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             armed_q, slave_q, read_q, dtack_q, timeout_q;
    logic             fcs_s;
    assign fcs_s       = ~fcs_sync_q[1];
    assign slave_cycle = slave_q;
    assign READ        = read_q;
    assign dtack       = dtack_q;
    assign timeout     = timeout_q;
    // vld_q masks the reset value of the synchronizer so a strobe held low across reset cannot arm us
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q    <= S_IDLE;
            fcs_sync_q <= 2'b11;
            rd_sync_q  <= 2'b00;
            vld_q      <= 2'b00;
            addr_q     <= 8'h00;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            slave_q    <= 1'b0;
            read_q     <= 1'b0;
            dtack_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            fcs_sync_q <= {fcs_sync_q[0], FCS_n};
            rd_sync_q  <= {rd_sync_q[0], READ_pin};
            vld_q      <= {vld_q[0], 1'b1};
            timeout_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fcs_s && armed_q) begin
                        addr_q  <= ADDR_HI;
                        read_q  <= rd_sync_q[1];
                        armed_q <= 1'b0;
                        state_q <= S_DECODE;
                    end else if (!fcs_s && vld_q[1]) begin
                        armed_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (configured && addr_q == base_addr) begin
                        slave_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end else begin
                        read_q  <= 1'b0;
                        state_q <= S_IGNORE;
                    end
                end
                S_WAIT: begin
                    if (!fcs_s) begin
                        slave_q <= 1'b0;
                        read_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (sid_dtack || scsi_dtack) begin
                        dtack_q <= 1'b1;
                        state_q <= S_TERM;
                    end else if (cnt_q == LAST) begin
                        dtack_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= S_TERM;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_TERM: begin
                    if (!fcs_s) begin
                        dtack_q <= 1'b0;
                        slave_q <= 1'b0;
                        read_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_IGNORE: begin
                    if (!fcs_s) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
